// File: rtl/mult_seq_pkg.sv
// Shared definitions for the nibble-serial multiplier controller: nibble width,
// FSM state encoding and a ceiling-log2 helper for the pair-index counter width.
package mult_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/multiplier_4bit.sv
// Combinational 4x4 unsigned multiplier producing the full 8-bit product.
module multiplier_4bit
    import mult_seq_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] product
);

    assign product = (2*NIB_W)'(a) * (2*NIB_W)'(b);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Wide unsigned multiply built from one 4x4 multiplier: one nibble pair per clock,
// shift-accumulated, with valid/ready handshakes on operand and result sides.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int N_NIB = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIB_W*N_NIB-1:0]    a,
    input  logic [NIB_W*N_NIB-1:0]    b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*NIB_W*N_NIB-1:0]  product,
    output logic                      busy
);

    localparam int OP_W  = NIB_W * N_NIB;
    localparam int ACC_W = 2 * OP_W;
    localparam int NPAIR = N_NIB * N_NIB;
    localparam int IDX_W = (clog2(NPAIR) < 1) ? 1 : clog2(NPAIR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAIR - 1);

    state_t             state;
    state_t             state_next;
    logic [OP_W-1:0]    a_reg;
    logic [OP_W-1:0]    b_reg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   pp_shift;
    logic [ACC_W-1:0]   acc_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   i_nib;
    logic [IDX_W-1:0]   j_nib;
    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [2*NIB_W-1:0] pp;
    logic               last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = MUL;
            MUL:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            MUL:     busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // idx walks a-nibbles fastest: i = idx % N_NIB, j = idx / N_NIB
    always_comb begin
        i_nib    = IDX_W'(idx % N_NIB);
        j_nib    = IDX_W'(idx / N_NIB);
        a_nib    = a_reg[int'(i_nib)*NIB_W +: NIB_W];
        b_nib    = b_reg[int'(j_nib)*NIB_W +: NIB_W];
        pp_shift = ACC_W'(pp) << (NIB_W * (int'(i_nib) + int'(j_nib)));
        acc_next = acc + pp_shift;
        last     = (idx == LAST_IDX);
    end

    multiplier_4bit u_mul (
        .a       (a_nib),
        .b       (b_nib),
        .product (pp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            idx     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    if (last) product <= acc_next;
                    else      idx     <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl at N_NIB = 2 (main), 1 and 4, against a plain
// a*b reference with fixed N_NIB^2 latency.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, busy2;
    logic [7:0]  a2 = '0, b2 = '0;
    logic [15:0] product2;

    logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, busy1;
    logic [3:0]  a1 = '0, b1 = '0;
    logic [7:0]  product1;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, busy4;
    logic [15:0] a4 = '0, b4 = '0;
    logic [31:0] product4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.N_NIB(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .product(product2), .busy(busy2)
    );

    mult_seq_ctrl #(.N_NIB(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .product(product1), .busy(busy1)
    );

    mult_seq_ctrl #(.N_NIB(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .product(product4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One N_NIB=2 transaction; hold = cycles out_ready stays low once out_valid is seen
    task automatic run_op2(input logic [7:0] ta, input logic [7:0] tbv, input int hold);
        logic [15:0] expv;
        int lat;
        expv = 16'(ta) * 16'(tbv);
        lat = 0;
        while (in_ready2 !== 1'b1 && lat < 20) begin tick(); lat++; end
        out_ready2 = (hold == 0);
        in_valid2 = 1'b1; a2 = ta; b2 = tbv;
        tick();
        in_valid2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom);
        n_checks++;
        if (in_ready2 !== 1'b0 || busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_state: in_ready=%b busy=%b required 0/1", in_ready2, busy2);
        end
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 40) begin tick(); lat++; end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL latency2 %h*%h: got %0d cycles required 4", ta, tbv, lat);
        end
        n_checks++;
        if (product2 !== expv) begin
            n_fail++;
            $display("FAIL product2 %h*%h: got %h required %h", ta, tbv, product2, expv);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            n_checks++;
            if (out_valid2 !== 1'b1 || product2 !== expv || in_ready2 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold %0d: out_valid=%b in_ready=%b product=%h required 1/0/%h",
                         h, out_valid2, in_ready2, product2, expv);
            end
        end
        out_ready2 = 1'b1;
        tick();
        n_checks++;
        if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || busy2 !== 1'b0 || product2 !== expv) begin
            n_fail++;
            $display("FAIL post_handshake: out_valid=%b in_ready=%b busy=%b product=%h required 0/1/0/%h",
                     out_valid2, in_ready2, busy2, product2, expv);
        end
    endtask

    task automatic run_op1(input logic [3:0] ta, input logic [3:0] tbv);
        logic [7:0] expv;
        int lat;
        expv = 8'(ta) * 8'(tbv);
        lat = 0;
        while (in_ready1 !== 1'b1 && lat < 20) begin tick(); lat++; end
        in_valid1 = 1'b1; a1 = ta; b1 = tbv;
        tick();
        in_valid1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 40) begin tick(); lat++; end
        n_checks++;
        if (lat !== 1 || product1 !== expv) begin
            n_fail++;
            $display("FAIL nnib1 %h*%h: got %h after %0d cycles required %h after 1",
                     ta, tbv, product1, lat, expv);
        end
        tick();
        n_checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL nnib1_handshake: in_ready=%b out_valid=%b required 1/0", in_ready1, out_valid1);
        end
    endtask

    task automatic run_op4(input logic [15:0] ta, input logic [15:0] tbv);
        logic [31:0] expv;
        int lat;
        expv = 32'(ta) * 32'(tbv);
        lat = 0;
        while (in_ready4 !== 1'b1 && lat < 20) begin tick(); lat++; end
        in_valid4 = 1'b1; a4 = ta; b4 = tbv;
        tick();
        in_valid4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom);
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 60) begin tick(); lat++; end
        n_checks++;
        if (lat !== 16 || product4 !== expv) begin
            n_fail++;
            $display("FAIL nnib4 %h*%h: got %h after %0d cycles required %h after 16",
                     ta, tbv, product4, lat, expv);
        end
        tick();
        n_checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL nnib4_handshake: in_ready=%b out_valid=%b required 1/0", in_ready4, out_valid4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || busy2 !== 1'b0 || product2 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset2: in_ready=%b out_valid=%b busy=%b product=%h required 1/0/0/0000",
                     in_ready2, out_valid2, busy2, product2);
        end
        n_checks++;
        if (in_ready1 !== 1'b1 || product1 !== 8'h0 || in_ready4 !== 1'b1 || product4 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_other: in_ready1=%b product1=%h in_ready4=%b product4=%h required 1/00/1/0",
                     in_ready1, product1, in_ready4, product4);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_op2(8'h00, 8'h00, 0);
        run_op2(8'hFF, 8'hFF, 0);
        run_op2(8'h0C, 8'h0C, 0);
        run_op2(8'h13, 8'h06, 0);
    endtask

    task automatic test_backpressure();
        run_op2(8'hF0, 8'h06, 6);
    endtask

    task automatic test_random();
        for (int k = 0; k < 15; k++)
            run_op2(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    endtask

    // in_valid held high through MUL and into the DONE handshake must be ignored
    task automatic test_busy_ignore();
        int lat;
        out_ready2 = 1'b1;
        in_valid2 = 1'b1; a2 = 8'h21; b2 = 8'h03;
        tick();
        a2 = 8'hFF; b2 = 8'hFF;
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 40) begin tick(); lat++; end
        n_checks++;
        if (lat !== 4 || product2 !== 16'h0063) begin
            n_fail++;
            $display("FAIL busy_ignore: got %h after %0d cycles required 0063 after 4", product2, lat);
        end
        tick();
        in_valid2 = 1'b0;
        n_checks++;
        if (in_ready2 !== 1'b1 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: in_ready=%b busy=%b required 1/0", in_ready2, busy2);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || product2 !== 16'h0063) begin
                n_fail++;
                $display("FAIL idle_quiet %0d: out_valid=%b in_ready=%b product=%h required 0/1/0063",
                         k, out_valid2, in_ready2, product2);
            end
        end
    endtask

    task automatic test_reset_mid();
        in_valid2 = 1'b1; a2 = 8'h55; b2 = 8'h77;
        tick();
        in_valid2 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || busy2 !== 1'b0 || product2 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b product=%h required 1/0/0/0000",
                     in_ready2, out_valid2, busy2, product2);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
                n_fail++;
                $display("FAIL discarded_op %0d: out_valid=%b in_ready=%b required 0/1",
                         k, out_valid2, in_ready2);
            end
        end
        run_op2(8'h04, 8'h04, 0);
    endtask

    task automatic test_nnib1();
        run_op1(4'hF, 4'h6);
        for (int k = 0; k < 5; k++) run_op1(4'($urandom), 4'($urandom));
    endtask

    task automatic test_nnib4();
        run_op4(16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 4; k++) run_op4(16'($urandom), 16'($urandom));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_nnib1();
        test_nnib4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
